sos_cascade_sequencer: RTL



---
 rtl/sos_cascade_sequencer_pkg.sv | 29 ++
 rtl/sos_cascade_sequencer_if.sv | 30 +++
 rtl/sos_cascade_sequencer_state_bank.sv | 40 ++++
 rtl/sos_cascade_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sos_cascade_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sos_pkg
// Brief    : Shared types and coefficient slot layout for the SOS sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int NUM_COEF = 5;

    // Step index doubles as the coefficient index within a section
    localparam logic [2:0] C_B0 = 3'd0;
    localparam logic [2:0] C_B1 = 3'd1;
    localparam logic [2:0] C_B2 = 3'd2;
    localparam logic [2:0] C_A1 = 3'd3;
    localparam logic [2:0] C_A2 = 3'd4;

    function automatic int coef_slot(input int sec, input int idx);
        return sec * NUM_COEF + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sos_cascade_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : sos_cascade_sequencer_if
// Brief     : Sample handshake, result and shared-multiplier signals.
// Revision  : 1.0 - initial release
// ============================================================================
interface sos_cascade_sequencer_if #(
    parameter int IIR_WD = 48,
    parameter int COF_WD = 32
);
    logic [IIR_WD-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [IIR_WD-1:0] out_data;
    logic              out_valid;
    logic [IIR_WD-1:0] mul_x;
    logic [COF_WD-1:0] mul_h;
    logic [IIR_WD-1:0] mul_p;

    modport slave (
        input  in_data, in_valid, mul_p,
        output in_ready, out_data, out_valid, mul_x, mul_h
    );

    modport master (
        output in_data, in_valid, mul_p,
        input  in_ready, out_data, out_valid, mul_x, mul_h
    );
endinterface
`default_nettype wire

// File: rtl/sos_cascade_sequencer_state_bank.sv
`default_nettype none
// ============================================================================
// Module   : sos_state_bank
// Brief    : Per-section s1/s2 delay registers, one shared read/write address.
// Revision : 1.0 - initial release
// ============================================================================
module sos_state_bank #(
    parameter int IIR_WD  = 48,
    parameter int NUM_SEC = 4,
    parameter int SEC_W   = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clr,
    input  wire logic [SEC_W-1:0]  i_addr,
    input  wire logic              i_wr_en,
    input  wire logic              i_wr_sel,
    input  wire logic [IIR_WD-1:0] i_wr_data,
    output logic      [IIR_WD-1:0] o_s1,
    output logic      [IIR_WD-1:0] o_s2
);
    logic [IIR_WD-1:0] r_s1 [NUM_SEC];
    logic [IIR_WD-1:0] r_s2 [NUM_SEC];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < NUM_SEC; i++) begin
                r_s1[i] <= '0;
                r_s2[i] <= '0;
            end
        end else if (i_wr_en) begin
            if (i_wr_sel) r_s2[i_addr] <= i_wr_data;
            else          r_s1[i_addr] <= i_wr_data;
        end
    end

    assign o_s1 = r_s1[i_addr];
    assign o_s2 = r_s2[i_addr];
endmodule
`default_nettype wire

// File: rtl/sos_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sos_cascade_sequencer
// Brief    : DF2T biquad cascade sharing one external multiply-and-shift unit.
// Revision : 1.0 - initial release
// ============================================================================
module sos_cascade_sequencer
    import sos_pkg::*;
#(
    parameter int IIR_WD  = 48,
    parameter int COF_WD  = 32,
    parameter int NUM_SEC = 4
) (
    input  wire logic                               clk,
    input  wire logic                               rst,
    input  wire logic                               clr,
    input  wire logic [NUM_SEC*NUM_COEF*COF_WD-1:0] coefs,
    sos_cascade_sequencer_if.slave                  bus
);
    localparam int               c_sec_w    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
    localparam logic [c_sec_w-1:0] c_last_sec = c_sec_w'(NUM_SEC - 1);

    seq_state_t          r_state;
    logic [c_sec_w-1:0]  r_sec;
    logic [2:0]          r_step;
    logic [IIR_WD-1:0]   r_x;
    logic [IIR_WD-1:0]   r_y;
    logic [IIR_WD-1:0]   r_t1;
    logic [IIR_WD-1:0]   r_t2;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [IIR_WD-1:0]   r_out_data;

    logic [IIR_WD-1:0]   w_mul_x;
    logic [COF_WD-1:0]   w_mul_h;
    int                  w_slot;
    logic [IIR_WD-1:0]   w_s1;
    logic [IIR_WD-1:0]   w_s2;
    logic                w_wr_en;
    logic                w_wr_sel;
    logic [IIR_WD-1:0]   w_wr_data;

    // Operands are decoded from the current step so the product returns
    // combinationally and lands together with the state update.
    always_comb begin
        w_mul_x = '0;
        w_mul_h = '0;
        w_slot  = 0;
        if (r_state == RUN) begin
            w_slot  = coef_slot(int'(r_sec), int'(r_step));
            w_mul_x = (r_step < C_A1) ? r_x : r_y;
            w_mul_h = coefs[w_slot*COF_WD +: COF_WD];
        end
    end

    assign w_wr_en   = (r_state == RUN) && ((r_step == C_A1) || (r_step == C_A2));
    assign w_wr_sel  = (r_step == C_A2);
    assign w_wr_data = ((r_step == C_A2) ? r_t2 : r_t1) - bus.mul_p;

    sos_state_bank #(
        .IIR_WD  (IIR_WD),
        .NUM_SEC (NUM_SEC),
        .SEC_W   (c_sec_w)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (clr),
        .i_addr    (r_sec),
        .i_wr_en   (w_wr_en),
        .i_wr_sel  (w_wr_sel),
        .i_wr_data (w_wr_data),
        .o_s1      (w_s1),
        .o_s2      (w_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sec       <= '0;
            r_step      <= C_B0;
            r_x         <= '0;
            r_y         <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            // Abort: drop any sample in flight but keep the last result visible
            r_state     <= IDLE;
            r_sec       <= '0;
            r_step      <= C_B0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x        <= bus.in_data;
                        r_sec      <= '0;
                        r_step     <= C_B0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    case (r_step)
                        C_B0:    r_y  <= bus.mul_p + w_s1;
                        C_B1:    r_t1 <= bus.mul_p + w_s2;
                        C_B2:    r_t2 <= bus.mul_p;
                        C_A2:    r_x  <= r_y;
                        default: ;
                    endcase
                    if (r_step == C_A2) begin
                        r_step <= C_B0;
                        if (r_sec == c_last_sec) r_state <= DONE;
                        else                     r_sec   <= r_sec + 1'b1;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                DONE: begin
                    r_out_data  <= r_x;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready & ~clr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.mul_x     = w_mul_x;
    assign bus.mul_h     = w_mul_h;
endmodule
`default_nettype wire
